// File: rtl/sysid_chk_pkg.sv
// Shared definitions for the system-ID boot checker.
//   state_t        : sequencer states
//   SYSID_ADDR_*   : word addresses inside the system-ID slave
//   TMO_CNT_W      : width of the per-read timeout counter
//   RETRY_CNT_W    : width of the full-sequence retry counter
package sysid_chk_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WT_ID,
    ST_RD_TS,
    ST_WT_TS,
    ST_CHECK,
    ST_DONE,
    ST_RETRY,
    ST_FAIL
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int TMO_CNT_W   = 16;
  localparam int RETRY_CNT_W = 4;

endpackage

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that checks the system-ID slave after reset or on
// demand. It reads word 0 (ID) and word 1 (build timestamp), compares them
// with the expected constants and reports the result. Only one read is ever
// outstanding; a read that does not complete within TIMEOUT_CYCLES restarts
// the whole sequence, up to MAX_RETRIES times, after which the check fails.
//
// Ports
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : 1-cycle pulse, (re)starts when idle/done/fail
//   avm_address         : 0 = ID word, 1 = timestamp word
//   avm_read            : read request, held while avm_waitrequest is high
//   avm_readdata        : read data, qualified by avm_readdatavalid
//   avm_waitrequest     : slave/interconnect stall
//   avm_readdatavalid   : read data qualifier (may coincide with accept)
//   busy                : sequence in progress
//   done                : sequence finished, pass or fail
//   id_ok, ts_ok        : captured words match expected constants
//   timeout_err         : retries exhausted without completing
//   id_value, ts_value  : captured words
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1485989023,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter int          MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRIES);
  // The counter holds the number of cycles already spent on the current
  // word, so the limit is hit while it still reads TIMEOUT_CYCLES-1.
  localparam logic [TMO_CNT_W-1:0]   TMO_LAST    = TIMEOUT_CYCLES - 16'd1;

  state_t                 state;
  logic [TMO_CNT_W-1:0]   tmo_cnt;
  logic [RETRY_CNT_W-1:0] retry_cnt;
  logic                   auto_pend;

  logic in_rd;
  logic in_wt;
  logic is_ts;
  logic accept;
  logic capture;
  logic tmo_hit;
  logic launch;

  assign in_rd   = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign in_wt   = (state == ST_WT_ID) || (state == ST_WT_TS);
  assign is_ts   = (state == ST_RD_TS) || (state == ST_WT_TS);
  assign accept  = in_rd && !avm_waitrequest;
  // Zero-latency data is only trusted in the accept cycle itself; a stray
  // readdatavalid while still stalled belongs to no read of ours.
  assign capture = avm_readdatavalid && (in_wt || accept);
  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign launch  = ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL))
                   && (start || auto_pend);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      auto_pend   <= AUTO_START;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      // The auto-start request is only honoured in the first cycle out of reset.
      auto_pend <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (launch) begin
            state       <= ST_RD_ID;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
          end
        end

        ST_RD_ID, ST_WT_ID, ST_RD_TS, ST_WT_TS: begin
          if (capture) begin
            if (!is_ts) begin
              id_value    <= avm_readdata;
              state       <= ST_RD_TS;
              avm_read    <= 1'b1;
              avm_address <= SYSID_ADDR_TS;
              tmo_cnt     <= '0;
            end else begin
              ts_value <= avm_readdata;
              state    <= ST_CHECK;
              avm_read <= 1'b0;
            end
          end else if (tmo_hit) begin
            // Abandon the read; any late readdatavalid lands in RETRY/FAIL
            // and is ignored there.
            avm_read <= 1'b0;
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_RETRY;
            end else begin
              state       <= ST_FAIL;
              busy        <= 1'b0;
              done        <= 1'b1;
              timeout_err <= 1'b1;
              id_ok       <= 1'b0;
              ts_ok       <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (accept) begin
              avm_read <= 1'b0;
              state    <= is_ts ? ST_WT_TS : ST_WT_ID;
            end
          end
        end

        // One idle cycle with read low, so a stalled request is dropped
        // before the address changes back to the ID word.
        ST_RETRY: begin
          state       <= ST_RD_ID;
          avm_read    <= 1'b1;
          avm_address <= SYSID_ADDR_ID;
          tmo_cnt     <= '0;
        end

        ST_CHECK: begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TS);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end

        default: begin
          state    <= ST_IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
